// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared widths, FSM encoding and clog2 helper for the multi-channel FIR MAC
package fir_pkg;

    function automatic int clog2(input int value);
        int v;
        int r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    localparam int FIR_DATA_W = 24;
    localparam int FIR_COEF_W = 24;
    localparam int FIR_TAPS   = 256;
    localparam int FIR_ACC_W  = FIR_DATA_W + FIR_COEF_W + clog2(FIR_TAPS);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCUM  = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;
    localparam logic [1:0] ST_OUTPUT = 2'd3;

endpackage

// File: rtl/fir_mult_pipe.sv
// rtl/fir_mult_pipe.sv - signed multiplier followed by MULT_LAT pipeline registers
module fir_mult_pipe #(
    parameter int DATA_W   = 24,
    parameter int COEF_W   = 24,
    parameter int MULT_LAT = 3
) (
    input  logic                             i_clock,
    input  logic                             i_reset_n,
    input  logic signed [DATA_W-1:0]         i_a,
    input  logic signed [COEF_W-1:0]         i_b,
    output logic signed [DATA_W+COEF_W-1:0]  o_p
);

    localparam int PROD_W = DATA_W + COEF_W;

    logic signed [PROD_W-1:0] r_pipe [MULT_LAT];

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < MULT_LAT; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= i_a * i_b;
            for (int i = 1; i < MULT_LAT; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_p = r_pipe[MULT_LAT-1];

endmodule

// File: rtl/fir_mac_multi.sv
// rtl/fir_mac_multi.sv - multi-channel frame FIR MAC sharing one coefficient stream, rounded and saturated output
module fir_mac_multi
    import fir_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int DATA_W   = FIR_DATA_W,
    parameter int COEF_W   = FIR_COEF_W,
    parameter int TAPS     = FIR_TAPS,
    parameter int MULT_LAT = 3,
    parameter int OUT_W    = 24,
    parameter int SHIFT    = 32
) (
    input  logic                         i_clock,
    input  logic                         i_reset_n,
    input  logic                         i_start,
    input  logic                         i_in_valid,
    input  logic [CHANNELS*DATA_W-1:0]   i_in_data,
    input  logic [COEF_W-1:0]            i_in_coef,
    output logic                         o_busy,
    output logic                         o_out_valid,
    output logic [CHANNELS*OUT_W-1:0]    o_out_data,
    output logic [CHANNELS-1:0]          o_out_sat
);

    localparam int ACC_W  = DATA_W + COEF_W + clog2(TAPS);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int TAP_W  = clog2(TAPS);
    localparam int DRN_W  = clog2(MULT_LAT + 1) + 1;
    localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic [ACC_W:0] RND = (SHIFT > 0) ? ((ACC_W+1)'(1) << RND_SH) : '0;
    localparam logic signed [ACC_W:0] OUT_MAX = {{(ACC_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] OUT_MIN = {{(ACC_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};

    logic [1:0]                  r_state;
    logic [TAP_W-1:0]            r_tap;
    logic [DRN_W-1:0]            r_drain;
    logic                        r_in_vld;
    logic [CHANNELS*DATA_W-1:0]  r_in_data;
    logic [COEF_W-1:0]           r_in_coef;
    logic [MULT_LAT-1:0]         r_vpipe;
    logic signed [ACC_W-1:0]     r_acc [CHANNELS];
    logic                        r_busy;
    logic                        r_out_valid;
    logic [CHANNELS*OUT_W-1:0]   r_out_data;
    logic [CHANNELS-1:0]         r_out_sat;

    logic signed [PROD_W-1:0]    w_prod [CHANNELS];
    logic [CHANNELS*OUT_W-1:0]   w_res;
    logic [CHANNELS-1:0]         w_sat;

    // Accepted samples are registered once before the multiplier so that the
    // accepting edge, not the multiplier input, starts the latency count.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= ST_IDLE;
            r_tap       <= '0;
            r_drain     <= '0;
            r_in_vld    <= 1'b0;
            r_in_data   <= '0;
            r_in_coef   <= '0;
            r_vpipe     <= '0;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sat   <= '0;
        end else begin
            r_out_valid <= 1'b0;
            r_in_vld    <= 1'b0;
            r_in_data   <= i_in_data;
            r_in_coef   <= i_in_coef;
            r_vpipe     <= (r_vpipe << 1) | MULT_LAT'(r_in_vld);
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state <= ST_ACCUM;
                        r_busy  <= 1'b1;
                        r_tap   <= '0;
                    end
                end
                ST_ACCUM: begin
                    if (i_in_valid) begin
                        r_in_vld <= 1'b1;
                        r_tap    <= r_tap + TAP_W'(1);
                        if (r_tap == TAP_W'(TAPS - 1)) begin
                            r_state <= ST_DRAIN;
                            r_drain <= '0;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (r_drain == DRN_W'(MULT_LAT)) begin
                        r_state <= ST_OUTPUT;
                    end else begin
                        r_drain <= r_drain + DRN_W'(1);
                    end
                end
                ST_OUTPUT: begin
                    r_state     <= ST_IDLE;
                    r_busy      <= 1'b0;
                    r_out_valid <= 1'b1;
                    r_out_data  <= w_res;
                    r_out_sat   <= w_sat;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_acc[c] <= '0;
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (r_state == ST_IDLE && i_start) begin
                    r_acc[c] <= '0;
                end else if (r_vpipe[MULT_LAT-1]) begin
                    r_acc[c] <= r_acc[c] + ACC_W'(w_prod[c]);
                end
            end
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic signed [ACC_W:0] w_sum;
        logic signed [ACC_W:0] w_shr;

        fir_mult_pipe #(
            .DATA_W   (DATA_W),
            .COEF_W   (COEF_W),
            .MULT_LAT (MULT_LAT)
        ) u_mult (
            .i_clock   (i_clock),
            .i_reset_n (i_reset_n),
            .i_a       (r_in_data[c*DATA_W +: DATA_W]),
            .i_b       (r_in_coef),
            .o_p       (w_prod[c])
        );

        // One guard bit keeps the rounding add from wrapping at the accumulator extreme.
        assign w_sum    = {r_acc[c][ACC_W-1], r_acc[c]} + RND;
        assign w_shr    = w_sum >>> SHIFT;
        assign w_sat[c] = (w_shr > OUT_MAX) || (w_shr < OUT_MIN);
        assign w_res[c*OUT_W +: OUT_W] = (w_shr > OUT_MAX) ? OUT_MAX[OUT_W-1:0] :
                                         (w_shr < OUT_MIN) ? OUT_MIN[OUT_W-1:0] :
                                                             w_shr[OUT_W-1:0];
    end

    assign o_busy      = r_busy;
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_out_sat   = r_out_sat;

endmodule

// File: tb/tb_fir_mac_multi.sv
// tb/tb_fir_mac_multi.sv - randomized self-checking bench for fir_mac_multi against a sum-of-products model
module tb_fir_mac_multi;

    localparam int CH = 2;
    localparam int DW = 24;
    localparam int OW = 24;
    localparam int ML = 3;
    localparam int SMALL_TAPS = 8;
    localparam int BIG_TAPS   = 256;
    localparam int SHIFTS [3] = '{0, 4, 16};

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic            s_start, s_valid;
    logic [CH*DW-1:0] s_data;
    logic [DW-1:0]   s_coef;
    logic            c_start, c_valid;
    logic [CH*DW-1:0] c_data;
    logic [DW-1:0]   c_coef;

    logic            a_busy, a_ov, b_busy, b_ov, c_busy, c_ov;
    logic [CH*OW-1:0] a_od, b_od, c_od;
    logic [CH-1:0]   a_os, b_os, c_os;

    fir_mac_multi #(.CHANNELS(CH), .DATA_W(DW), .COEF_W(DW), .TAPS(SMALL_TAPS),
                    .MULT_LAT(ML), .OUT_W(OW), .SHIFT(0)) u_dut_a (
        .i_clock(clk), .i_reset_n(rst_n), .i_start(s_start), .i_in_valid(s_valid),
        .i_in_data(s_data), .i_in_coef(s_coef), .o_busy(a_busy), .o_out_valid(a_ov),
        .o_out_data(a_od), .o_out_sat(a_os));

    fir_mac_multi #(.CHANNELS(CH), .DATA_W(DW), .COEF_W(DW), .TAPS(SMALL_TAPS),
                    .MULT_LAT(ML), .OUT_W(OW), .SHIFT(4)) u_dut_b (
        .i_clock(clk), .i_reset_n(rst_n), .i_start(s_start), .i_in_valid(s_valid),
        .i_in_data(s_data), .i_in_coef(s_coef), .o_busy(b_busy), .o_out_valid(b_ov),
        .o_out_data(b_od), .o_out_sat(b_os));

    fir_mac_multi #(.CHANNELS(CH), .DATA_W(DW), .COEF_W(DW), .TAPS(BIG_TAPS),
                    .MULT_LAT(ML), .OUT_W(OW), .SHIFT(16)) u_dut_c (
        .i_clock(clk), .i_reset_n(rst_n), .i_start(c_start), .i_in_valid(c_valid),
        .i_in_data(c_data), .i_in_coef(c_coef), .o_busy(c_busy), .o_out_valid(c_ov),
        .o_out_data(c_od), .o_out_sat(c_os));

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: plain rounding formula, then clamp to the signed OUT_W range.
    function automatic void model(input longint acc, input int shift, output longint r, output longint sat);
        longint hi, lo;
        hi = (longint'(1) <<< (OW - 1)) - 1;
        lo = -(longint'(1) <<< (OW - 1));
        if (shift > 0) r = (acc + (longint'(1) <<< (shift - 1))) >>> shift;
        else           r = acc;
        sat = 0;
        if (r > hi) begin r = hi; sat = 1; end
        if (r < lo) begin r = lo; sat = 1; end
    endfunction

    function automatic int rnd(input int mag);
        logic signed [DW-1:0] s;
        s = DW'($urandom);
        return int'(s) >>> (DW - mag);
    endfunction

    function automatic logic get_busy(input int w);
        case (w)
            0:       return a_busy;
            1:       return b_busy;
            default: return c_busy;
        endcase
    endfunction

    function automatic logic get_ov(input int w);
        case (w)
            0:       return a_ov;
            1:       return b_ov;
            default: return c_ov;
        endcase
    endfunction

    function automatic longint get_out(input int w, input int ch);
        logic [CH*OW-1:0] v;
        case (w)
            0:       v = a_od;
            1:       v = b_od;
            default: v = c_od;
        endcase
        return longint'($signed(v[ch*OW +: OW]));
    endfunction

    function automatic longint get_sat(input int w, input int ch);
        case (w)
            0:       return longint'(a_os[ch]);
            1:       return longint'(b_os[ch]);
            default: return longint'(c_os[ch]);
        endcase
    endfunction

    task automatic drive(input bit big, input logic st, input logic vl,
                         input logic [CH*DW-1:0] dat, input logic [DW-1:0] cf);
        if (big) begin
            c_start = st; c_valid = vl; c_data = dat; c_coef = cf;
        end else begin
            s_start = st; s_valid = vl; s_data = dat; s_coef = cf;
        end
    endtask

    function automatic logic [CH*DW-1:0] junk();
        return {$urandom, $urandom};
    endfunction

    // mode: 0 continuous, 1 alternating bubble/sample, 2 random gaps.
    // mag: 1..24 random width, 0 fixed (1,-1,3), -1 all max, -2 max/min.
    task automatic run_frame(input string name, input bit big, input int mode, input int mag, input bit disturb);
        int taps, first, last, t, cyc, n;
        int d [CH][BIG_TAPS];
        int k [BIG_TAPS];
        longint acc [CH];
        logic [CH*DW-1:0] p;
        logic vl;
        bit hold_ok;
        longint er, es;

        taps  = big ? BIG_TAPS : SMALL_TAPS;
        first = big ? 2 : 0;
        last  = big ? 2 : 1;
        for (int ch = 0; ch < CH; ch++) acc[ch] = 0;
        for (int i = 0; i < taps; i++) begin
            k[i] = (mag == 0) ? 3 : (mag < 0) ? 32'h7FFFFF : rnd(mag);
            for (int ch = 0; ch < CH; ch++) begin
                if (mag == 0)       d[ch][i] = (ch == 0) ? 1 : -1;
                else if (mag == -1) d[ch][i] = 32'h7FFFFF;
                else if (mag == -2) d[ch][i] = (ch == 0) ? 32'h7FFFFF : -32'sh800000;
                else                d[ch][i] = rnd(mag);
                acc[ch] += longint'(d[ch][i]) * longint'(k[i]);
            end
        end

        if (disturb) begin
            for (int i = 0; i < 2; i++) begin
                @(negedge clk);
                drive(big, 1'b0, 1'b1, junk(), DW'($urandom));
            end
        end
        @(negedge clk);
        drive(big, 1'b1, disturb, junk(), DW'($urandom));
        @(negedge clk);
        check({name, ":busy_start"}, longint'(get_busy(first)), 1);

        t = 0; cyc = 0; hold_ok = 1;
        while (t < taps) begin
            if (mode == 0)      vl = 1'b1;
            else if (mode == 1) vl = cyc[0];
            else                vl = 1'($urandom_range(0, 1));
            for (int ch = 0; ch < CH; ch++) p[ch*DW +: DW] = DW'(d[ch][t]);
            drive(big, disturb && (cyc == 3), vl, vl ? p : junk(), vl ? DW'(k[t]) : DW'($urandom));
            @(negedge clk);
            for (int w = first; w <= last; w++) if (!get_busy(w)) hold_ok = 0;
            if (vl) t++;
            cyc++;
        end
        drive(big, 1'b0, 1'b0, junk(), DW'($urandom));
        if (mode == 1) check({name, ":frame_cycles"}, cyc, 2 * taps);

        n = 0;
        while (!get_ov(first) && n < 20) begin
            for (int w = first; w <= last; w++) if (!get_busy(w)) hold_ok = 0;
            @(negedge clk);
            n++;
        end
        check({name, ":latency"}, n, ML + 2);
        check({name, ":busy_hold"}, hold_ok, 1);
        for (int w = first; w <= last; w++) begin
            check($sformatf("%s:dut%0d:ov", name, w), longint'(get_ov(w)), 1);
            check($sformatf("%s:dut%0d:busy_end", name, w), longint'(get_busy(w)), 0);
            for (int ch = 0; ch < CH; ch++) begin
                model(acc[ch], SHIFTS[w], er, es);
                check($sformatf("%s:dut%0d:ch%0d:data", name, w, ch), get_out(w, ch), er);
                check($sformatf("%s:dut%0d:ch%0d:sat", name, w, ch), get_sat(w, ch), es);
            end
        end
        @(negedge clk);
        check({name, ":ov_pulse"}, longint'(get_ov(first)), 0);
        model(acc[0], SHIFTS[first], er, es);
        check({name, ":data_hold"}, get_out(first, 0), er);
    endtask

    task automatic reset_midframe();
        bit seen;
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, '0, '0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive(1'b0, 1'b0, 1'b1, {24'hFFFFFF, 24'h000001}, 24'd3);
        end
        @(negedge clk);
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        #1;
        check("rst_mid:busy_a", longint'(a_busy), 0);
        check("rst_mid:busy_b", longint'(b_busy), 0);
        check("rst_mid:data_a", longint'(a_od), 0);
        check("rst_mid:sat_b", longint'(b_os), 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (a_ov || b_ov) seen = 1;
        end
        check("rst_mid:no_out_valid", seen, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        repeat (2) @(negedge clk);
        check("reset:busy_a", longint'(a_busy), 0);
        check("reset:ov_a", longint'(a_ov), 0);
        check("reset:data_a", longint'(a_od), 0);
        check("reset:sat_a", longint'(a_os), 0);
        check("reset:busy_c", longint'(c_busy), 0);
        check("reset:data_c", longint'(c_od), 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_frame("fixed_cont", 1'b0, 0, 0, 1'b0);
        run_frame("fixed_toggle", 1'b0, 1, 0, 1'b0);
        run_frame("fixed_disturb", 1'b0, 0, 0, 1'b1);
        reset_midframe();
        run_frame("fixed_after_rst", 1'b0, 0, 0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            run_frame($sformatf("rand%0d", i), 1'b0, $urandom_range(0, 2),
                      (i % 4 == 3) ? 24 : 10 + 2 * (i % 4), i[0]);
        end
        run_frame("big_max", 1'b1, 0, -1, 1'b0);
        run_frame("big_maxmin", 1'b1, 2, -2, 1'b0);
        run_frame("big_rand", 1'b1, 2, 14, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/fir_mac_multi.md
Name: fir_mac_multi

Overview:
- Parametrised successor to the single-channel 24x24 FIR multiply-accumulate engine.
- Runs CHANNELS parallel MACs (e.g. I and Q) that share one coefficient stream.
- Frame-based with a start/valid handshake and tolerates gaps in input samples.
- Produces a rounded, saturated OUT_W result per channel with a done strobe. Sits between the coefficient/sample RAM sequencer and the decimator output register in the receive chain.

Parameters:
- CHANNELS, 2, number of parallel data channels sharing the coefficient.
- DATA_W, 24, signed sample width.
- COEF_W, 24, signed coefficient width.
- TAPS, 256, samples accumulated per frame (power of two, >=2).
- MULT_LAT, 3, pipeline registers inside the multiplier (>=1).
- OUT_W, 24, output width per channel.
- SHIFT, 32, right shift applied to the accumulator before output.
- ACC_W, localparam, DATA_W+COEF_W+clog2(TAPS), 56 by default.

Ports:
- clock, in, 1, system clock, rising edge.
- reset_n, in, 1, asynchronous active-low reset.
- start, in, 1, one-cycle pulse that begins a frame.
- in_valid, in, 1, in_data/in_coef valid this cycle.
- in_data, in, CHANNELS*DATA_W, packed signed samples, channel 0 in the LSBs.
- in_coef, in, COEF_W, signed coefficient shared by all channels.
- busy, out, 1, high from the start edge until out_valid is emitted.
- out_valid, out, 1, one-cycle pulse when a frame result is ready.
- out_data, out, CHANNELS*OUT_W, packed rounded/saturated results.
- out_sat, out, CHANNELS, per-channel saturation flag, qualified by out_valid.

Behaviour:

Reset (async, reset_n=0):
- state=IDLE; busy=0, out_valid=0, out_data=0, out_sat=0.
- All accumulators, tap counter, valid pipe and multiplier pipeline registers cleared.

State machine, states IDLE, ACCUM, DRAIN, OUTPUT:
- IDLE: start=1 -> ACCUM; accumulators cleared, tap count=0, busy=1 on the next edge.
- ACCUM: each cycle with in_valid=1 issues one multiply per channel and increments the tap count. in_valid=0 inserts a bubble with no count change. After sample TAPS-1 is accepted -> DRAIN.
- DRAIN: waits MULT_LAT+1 cycles (counter) so the last product reaches the accumulator -> OUTPUT.
- OUTPUT: registers the rounded, saturated result. out_valid=1 for exactly one cycle; busy=0 in the same cycle -> IDLE.

Datapath:
- in_valid is delayed through a MULT_LAT-deep valid pipe alongside the products. acc += product only when the delayed valid bit is 1.
- Product width is DATA_W+COEF_W, sign-extended to ACC_W. No overflow is possible within TAPS terms.

Latency:
- Last sample accepted at edge k -> product registered at k+MULT_LAT, accumulated at k+MULT_LAT+1, out_valid high after edge k+MULT_LAT+2.
- Minimum frame length is TAPS+MULT_LAT+3 cycles from start.

Output arithmetic:
- r = (acc + 2^(SHIFT-1)) >>> SHIFT, round half up, arithmetic shift. With SHIFT=0 there is no rounding term.
- If r exceeds the OUT_W signed range, clamp to +(2^(OUT_W-1)-1) or -2^(OUT_W-1) and set out_sat for that channel.
- out_data/out_sat hold their values until the next OUTPUT.

Boundary cases:
- start while busy=1: ignored. The frame in progress is unaffected.
- in_valid outside ACCUM: ignored.
- start and in_valid in the same IDLE cycle: that sample is not accepted; the first sample is accepted on the following cycle.
- Reset asserted mid-frame: frame aborted and no out_valid is emitted.
- Each channel's rounding and saturation are independent.

Decomposition:
- Shared package fir_pkg holds:
  - clog2 function;
  - default width constants (DATA_W, COEF_W, ACC_W);
  - the state enum encoding (IDLE=0, ACCUM=1, DRAIN=2, OUTPUT=3).
- One sub-module, fir_mult_pipe: signed DATA_W x COEF_W multiplier with MULT_LAT registers and async active-low reset. One instance per channel, built with a generate loop.
- Round and saturate logic stays inline in the top level.

Test Plan:
1. TAPS=8, SHIFT=0, OUT_W=24; data ch0=1, ch1=-1, coef=3, in_valid continuous -> out_valid 5 cycles after the 8th sample (MULT_LAT=3); out ch0=24, ch1=-24; out_sat=00.
2. Same settings, in_valid toggling 1/0 -> identical results (24/-24); the frame takes 8 extra cycles; busy stays high throughout.
3. TAPS=8, SHIFT=4; ch0 data=1, coef=3 (acc=24) -> out 2 (24+8=32, >>4). ch1 data=-1 (acc=-24) -> out -1 (-24+8=-16, >>4).
4. Default parameters, 256 taps of data=0x7FFFFF, coef=0x7FFFFF, SHIFT=16 -> both channels clamp to 0x7FFFFF; out_sat=11.
5. start pulsed again mid-ACCUM and in_valid pulsed while IDLE -> no effect; the result equals scenario 1.
6. reset_n driven low for 1 cycle at tap 5 -> outputs 0 and busy=0 at once; no out_valid. A fresh start then yields the scenario-1 result.
